risc_mem_arbiter: RTL
=====================

// Module: risc_mem_arbiter
// PURPOSE
//  Arbitrates a single shared 16-bit memory port between the IF stage (instruction fetch, read-only)
//  and the MEM stage (data load/store) of the pipelined RISC core in risc_soc. It serialises
//  accesses, enforces data-first priority with IF anti-starvation, honours halt, and times out
//  hung accesses.
// PARAMETERS
//  AW          16  address width (word address)
//  DW          16  data width
//  STARVE_MAX  4   consecutive data grants while if_req pending before IF is forced to win (1..15)
//  TIMEOUT     32  cycles in BUSY without mem_ready before abort (2..255)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  halt_i     in   1   holt from core: block new grants
//  if_req     in   1   fetch request, held until if_gnt
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   1-cycle pulse: fetch accepted
//  if_rvalid  out  1   1-cycle pulse: if_rdata valid
//  if_rdata   out  DW  fetched instruction
//  d_req      in   1   data request, held until d_gnt
//  d_we       in   1   1=store, 0=load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   1-cycle pulse: data access accepted
//  d_rvalid   out  1   1-cycle pulse: load data valid / store done
//  d_rdata    out  DW  load data (0 for store)
//  mem_req    out  1   held high for the whole access
//  mem_we     out  1   write enable, stable during access
//  mem_addr   out  AW  latched address
//  mem_wdata  out  DW  latched write data
//  mem_ready  in   1   memory completes access this cycle; mem_rdata valid
//  mem_rdata  in   DW  memory read data
//  err        out  1   1-cycle pulse: access aborted by timeout
//  halted     out  1   high while halt_i=1 and state==IDLE
// BEHAVIOUR
//  - All outputs registered except halted; reset: state=IDLE, all outputs 0, counters 0.
//  - FSM IDLE -> BUSY_IF | BUSY_D -> IDLE. Minimum one IDLE cycle between accesses.
//  - IDLE, halt_i=0: winner = data if d_req, unless if_req && starve_cnt==STARVE_MAX, then IF;
//    else IF if if_req. Next edge: state BUSY_x, mem_req=1, mem_addr/we/wdata latched, x_gnt=1 for 1 cycle.
//  - IF accesses drive mem_we=0, mem_wdata=0.
//  - starve_cnt: +1 on data grant while if_req=1 (saturates at STARVE_MAX); cleared on IF grant.
//  - BUSY_x with mem_ready=1: next edge -> IDLE, mem_req=0, x_rvalid=1, x_rdata=mem_rdata
//    (d_rdata=0 for stores). Access latency grant->rvalid = mem_ready delay + 1 cycle; min 2.
//  - tmo_cnt counts BUSY cycles; reaching TIMEOUT-1 with mem_ready=0 -> IDLE, err=1,
//    x_rvalid=1 with x_rdata=16'hDEAD. mem_ready on that same cycle wins (normal completion, no err).
//  - halt_i=1: no grant from IDLE; in-flight access completes normally; resumes when halt_i drops.
//  - Requests dropped before grant are ignored (no grant issued). mem_ready in IDLE ignored.
//  - rst asserted mid-access: immediate IDLE, outputs 0, in-flight access discarded, no rvalid/err.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_if_cnt[15:0], stat_d_cnt[15:0], stat_tmo_cnt[7:0]:
//    count IF grants, data grants, timeouts; wrap on overflow; reset 0.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 Fetch only: if_req, if_addr=16'h0010, mem_ready 1 cycle after mem_req, mem_rdata=16'h1234 ->
//    if_gnt pulse, mem_addr=16'h0010, mem_we=0, if_rvalid with if_rdata=16'h1234 2 cycles after gnt.
//  2 Contention: if_req and d_req (load 16'h0040) same cycle -> d_gnt first; IF granted after IDLE gap.
//  3 Starvation: if_req held, d_req held, STARVE_MAX=4 -> 4 d_gnt, then if_gnt, starve_cnt=0.
//  4 Store: d_we=1, d_addr=16'h0080, d_wdata=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF, d_rvalid, d_rdata=0.
//  5 Timeout: mem_ready never asserted, TIMEOUT=32 -> err and d_rvalid with 16'hDEAD 32 cycles after gnt.
//  6 Halt/reset: halt_i=1 during access -> completes, then halted=1, no gnt; rst mid-access -> all outputs 0.

Source files
------------

// File: rtl/risc_mem_arbiter_if.sv
// Bus bundle for risc_mem_arbiter: core-side IF/MEM requests plus the shared memory port.
// "master" is the arbiter's view; "slave" is the environment (core stages and memory).
interface risc_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          halt_i;
  logic          halted;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          err;

  modport master (
    input  halt_i, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output halted, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    output halt_i, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  halted, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/risc_mem_arbiter.sv
// Shared memory port arbiter: data-first priority with IF anti-starvation, halt and access timeout.
// Optional grant/timeout statistics counters are enabled by defining ARB_STATS_EN.
module risc_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                clk,
  input  logic                rst,
  risc_mem_arbiter_if.master  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         stat_if_cnt,
  output logic [15:0]         stat_d_cnt,
  output logic [7:0]          stat_tmo_cnt
`endif
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [DW-1:0] ABORT_DATA = DW'(16'hDEAD);

  logic [1:0] state_reg;
  logic [3:0] starve_cnt_reg;
  logic [7:0] tmo_cnt_reg;
  logic       pick_if;
  logic       pick_d;
  logic       finish;
  logic       timed_out;

  // Data wins unless IF has been passed over STARVE_MAX times in a row.
  always_comb begin
    pick_if = 1'b0;
    pick_d  = 1'b0;
    if (state_reg == ST_IDLE && !bus.halt_i) begin
      if (bus.if_req && (!bus.d_req || starve_cnt_reg == STARVE_LIM))
        pick_if = 1'b1;
      else if (bus.d_req)
        pick_d = 1'b1;
    end
  end

  // mem_ready on the last allowed cycle still counts as a normal completion.
  assign timed_out = (state_reg != ST_IDLE) && !bus.mem_ready && (tmo_cnt_reg == TMO_LAST);
  assign finish    = (state_reg != ST_IDLE) && (bus.mem_ready || timed_out);

  assign bus.halted = bus.halt_i && (state_reg == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      bus.if_gnt     <= 1'b0;
      bus.if_rvalid  <= 1'b0;
      bus.if_rdata   <= {DW{1'b0}};
      bus.d_gnt      <= 1'b0;
      bus.d_rvalid   <= 1'b0;
      bus.d_rdata    <= {DW{1'b0}};
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= {AW{1'b0}};
      bus.mem_wdata  <= {DW{1'b0}};
      bus.err        <= 1'b0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.err       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          tmo_cnt_reg <= '0;
          if (pick_if) begin
            state_reg      <= ST_BUSY_IF;
            bus.mem_req    <= 1'b1;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= bus.if_addr;
            bus.mem_wdata  <= {DW{1'b0}};
            bus.if_gnt     <= 1'b1;
            starve_cnt_reg <= '0;
          end else if (pick_d) begin
            state_reg     <= ST_BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.d_gnt     <= 1'b1;
            if (bus.if_req && starve_cnt_reg != STARVE_LIM)
              starve_cnt_reg <= starve_cnt_reg + 4'd1;
          end
        end
        ST_BUSY_IF, ST_BUSY_D: begin
          if (finish) begin
            state_reg   <= ST_IDLE;
            bus.mem_req <= 1'b0;
            bus.err     <= timed_out;
            if (state_reg == ST_BUSY_IF) begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= timed_out ? ABORT_DATA : bus.mem_rdata;
            end else begin
              bus.d_rvalid <= 1'b1;
              if (timed_out)
                bus.d_rdata <= ABORT_DATA;
              else
                bus.d_rdata <= bus.mem_we ? {DW{1'b0}} : bus.mem_rdata;
            end
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_cnt  <= '0;
      stat_d_cnt   <= '0;
      stat_tmo_cnt <= '0;
    end else begin
      if (pick_if)
        stat_if_cnt <= stat_if_cnt + 16'd1;
      if (pick_d)
        stat_d_cnt <= stat_d_cnt + 16'd1;
      if (timed_out)
        stat_tmo_cnt <= stat_tmo_cnt + 8'd1;
    end
  end
`endif
endmodule
